// File: rtl/matrix_deser_pkg.sv
// Shared definitions for the nibble-stream deserializer scheduler:
// FSM state encoding and derived-width helpers.
package matrix_deser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

endpackage

// File: rtl/matrix_deser_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_i wins,
// searching upward and wrapping.
module rr_arbiter
  import matrix_deser_pkg::*;
#(
  parameter  int NREQ  = 2,
  localparam int SRC_W = src_w(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [SRC_W-1:0] last_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [SRC_W-1:0] idx_o
);

  always_comb begin
    int  c;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    c       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(last_i) + k) % NREQ;
      if (!found && req_i[c]) begin
        found      = 1'b1;
        grant_o[c] = 1'b1;
        idx_o      = SRC_W'(c);
      end
    end
  end

endmodule

// File: rtl/matrix_deser_sched.sv
// Arbitrates NREQ serial beat streams onto one deserializer; each granted
// burst of SIZE beats becomes one packed word handed off via valid/ready.
module matrix_deser_sched
  import matrix_deser_pkg::*;
#(
  parameter  int DWIDTH = 4,
  parameter  int SIZE   = 16,
  parameter  int NREQ   = 2,
  localparam int CNT_W  = cnt_w(SIZE),
  localparam int SRC_W  = src_w(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE*DWIDTH-1:0]   out_data,
  output logic [SRC_W-1:0]         out_src,
  output logic                     busy,
  output logic [15:0]              word_cnt
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SRC_W-1:0]        rr_last_q, rr_last_d;
  logic [SIZE*DWIDTH-1:0]  out_data_q, out_data_d;
  logic [SRC_W-1:0]        out_src_q, out_src_d;
  logic                    out_valid_q, out_valid_d;
  logic [15:0]             word_cnt_q, word_cnt_d;

  logic [NREQ-1:0]         arb_grant;
  logic [SRC_W-1:0]        arb_idx;
  logic [DWIDTH-1:0]       beat;
  logic                    accept;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req_valid),
    .last_i  (rr_last_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  // rr_last_q doubles as the live grant once the burst has started.
  assign beat   = req_data[rr_last_q*DWIDTH +: DWIDTH];
  assign accept = (state_q == FILL) && !flush && req_valid[rr_last_q];

  for (genvar i = 0; i < NREQ; i++) begin : g_ready
    assign req_ready[i] = (state_q == FILL) && !flush && (rr_last_q == SRC_W'(i));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_last_d   = rr_last_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    word_cnt_d  = word_cnt_q;
    if (flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|arb_grant) begin
          rr_last_d = arb_idx;
          state_d   = FILL;
        end
        FILL: if (accept) begin
          out_data_d[cnt_q*DWIDTH +: DWIDTH] = beat;
          if (cnt_q == CNT_W'(SIZE-1)) begin
            cnt_d       = '0;
            out_src_d   = rr_last_q;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HOLD: if (out_ready) begin
          out_valid_d = 1'b0;
          word_cnt_d  = word_cnt_q + 16'd1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_last_q   <= SRC_W'(NREQ-1);
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_last_q   <= rr_last_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q != IDLE);
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_matrix_deser_sched.sv
// Scoreboard bench for matrix_deser_sched: directed bursts, stalls,
// back-pressure, flush and asynchronous reset.
module tb_matrix_deser_sched;

  localparam int DW = 4;
  localparam int SZ = 16;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SZ*DW-1:0] out_data;
  logic [0:0]    out_src;
  logic          busy;
  logic [15:0]   word_cnt;

  typedef struct packed {
    logic [63:0] d;
    logic [0:0]  s;
  } exp_t;
  exp_t q[$];

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [63:0] W1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] W3 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W4 = 64'h1357_9BDF_2468_ACE0;
  localparam logic [63:0] W5 = 64'hC0FF_EE00_DEAD_BEEF;
  localparam logic [63:0] WA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] W55 = 64'h5555_5555_5555_5555;

  matrix_deser_sched #(.DWIDTH(DW), .SIZE(SZ), .NREQ(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .busy      (busy),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: a word is handed off at the next rising edge whenever valid&ready.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_word: got %0h src %0d, expected no word", out_data, out_src);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("word_data", out_data, e.d);
        check("word_src", 64'(out_src), 64'(e.s));
      end
    end
  end

  task automatic feed(input int id, input logic [63:0] w, input int stall_at,
                      input int stall_len, input int flush_at, output int acc);
    int idx, guard, stall_left;
    bit stalled;
    idx = 0; guard = 0; stall_left = 0; stalled = 0; acc = 0;
    while (idx < SZ && guard < 400) begin
      if (idx == stall_at && !stalled) begin
        stalled    = 1;
        stall_left = stall_len;
      end
      req_valid[id] = (stall_left == 0);
      req_data[id*DW +: DW] = w[idx*DW +: DW];
      if (idx == flush_at && req_ready[id]) begin
        flush = 1'b1;
        @(negedge clk);
        check("flush_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        req_valid = '0;
        return;
      end
      @(negedge clk);
      if (stall_left > 0) begin
        check("stall_ready", 64'(req_ready), 64'(1 << id));
        stall_left--;
      end else if (req_ready[id]) begin
        idx++;
        acc++;
      end
      @(posedge clk); #1;
      guard++;
    end
    req_valid = '0;
    if (guard >= 400) check("feed_timeout", 64'(guard), 64'd0);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (busy && g < 100);
    if (busy) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b0; req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int acc, g;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_src", 64'(out_src), 64'd0);
    check("rst_word_cnt", 64'(word_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Single requester, ascending beats
    q.push_back('{d: W1, s: 1'b0});
    feed(0, W1, -1, 0, -1, acc);
    wait_idle();
    check("t1_word_cnt", 64'(word_cnt), 64'd1);

    // Both requesting continuously: alternation 0,1,0,1
    do_reset();
    q.push_back('{d: WA,  s: 1'b0});
    q.push_back('{d: W55, s: 1'b1});
    q.push_back('{d: WA,  s: 1'b0});
    q.push_back('{d: W55, s: 1'b1});
    req_data  = 8'h5A;
    req_valid = 2'b11;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (word_cnt != 16'd4 && g < 300);
    req_valid = '0;
    check("t2_word_cnt", 64'(word_cnt), 64'd4);
    wait_idle();

    // Stall of req0 at beat 7 with req1 also requesting
    q.push_back('{d: W3, s: 1'b0});
    @(posedge clk); #1;
    req_valid[1] = 1'b1;
    req_data[7:4] = 4'h5;
    feed(0, W3, 7, 3, -1, acc);
    check("t3_beats", 64'(acc), 64'd16);
    wait_idle();
    check("t3_word_cnt", 64'(word_cnt), 64'd5);

    // Back-pressure for 10 cycles
    out_ready = 1'b0;
    q.push_back('{d: W4, s: 1'b0});
    feed(0, W4, -1, 0, -1, acc);
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_valid", 64'(out_valid), 64'd1);
      check("t4_data", out_data, W4);
      check("t4_src", 64'(out_src), 64'd0);
      check("t4_ready", 64'(req_ready), 64'd0);
      check("t4_busy", 64'(busy), 64'd1);
    end
    @(posedge clk); #1;
    req_valid = '0;
    out_ready = 1'b1;
    wait_idle();
    check("t4_word_cnt", 64'(word_cnt), 64'd6);

    // Flush at beat 9, then a full clean burst
    feed(0, W5, -1, 0, 9, acc);
    check("t5_partial_beats", 64'(acc), 64'd9);
    @(negedge clk);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_word_cnt", 64'(word_cnt), 64'd6);
    q.push_back('{d: W5, s: 1'b0});
    @(posedge clk); #1;
    feed(0, W5, -1, 0, -1, acc);
    wait_idle();
    check("t5_word_cnt2", 64'(word_cnt), 64'd7);

    // Asynchronous reset mid-burst from req1
    @(posedge clk); #1;
    req_data[7:4] = 4'h3;
    req_valid = 2'b10;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!req_ready[1] && g < 20);
    check("t6_grant1", 64'(req_ready), 64'd2);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_ready", 64'(req_ready), 64'd0);
    check("t6_word_cnt", 64'(word_cnt), 64'd0);
    check("t6_data", out_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    check("t6_arb_cycle", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("t6_first_grant", 64'(req_ready), 64'd1);
    req_valid = '0;

    check("sb_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
